// File: rtl/lc3b_pkg.sv
// Shared LC-3b memory-interface definitions: FSM states, bus constants and
// the byte extension used by LDB.
package lc3b_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;
    localparam logic WE_ACTIVE = 1'b0;

    function automatic logic [15:0] byte_ext(input logic [7:0] b, input logic sgn);
        return {{8{sgn & b[7]}}, b};
    endfunction

endpackage

// File: rtl/lc3b_mem_access.sv
// LC-3b data-memory initiator: one LDB/LDW/STB/STW at a time, bus held for
// WAIT_CYCLES+1 cycles, result or error returned on a valid/ready response.
module lc3b_mem_access
    import lc3b_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_word,
    input  logic              req_signed,
    input  logic [15:0]       req_addr,
    input  logic [15:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [15:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we_n,
    output logic              mem_size,
    input  logic [15:0]       mem_rdata
);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                wr_q;
    logic                word_q;
    logic                sgn_q;
    logic                req_ready_q;
    logic                resp_valid_q;
    logic [15:0]         resp_rdata_q;
    logic                resp_err_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [15:0]         mem_wdata_q;
    logic                mem_we_n_q;
    logic                mem_size_q;
    logic                req_bad;

    assign req_bad = (req_word && req_addr[0]) || ((req_addr >> ADDR_W) != 16'h0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            word_q       <= 1'b0;
            sgn_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_n_q   <= ~WE_ACTIVE;
            mem_size_q   <= SIZE_BYTE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        wr_q        <= req_write;
                        word_q      <= req_word;
                        sgn_q       <= req_signed;
                        if (req_bad) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q     <= ST_ACCESS;
                            cnt_q       <= 4'(WAIT_CYCLES);
                            mem_addr_q  <= req_addr[ADDR_W-1:0];
                            mem_size_q  <= req_word ? SIZE_WORD : SIZE_BYTE;
                            mem_wdata_q <= req_word ? req_wdata : {8'h00, req_wdata[7:0]};
                            // Strobe is registered, so it is raised one edge ahead of the final cycle.
                            mem_we_n_q  <= (req_write && WAIT_CYCLES == 0) ? WE_ACTIVE : ~WE_ACTIVE;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1 && wr_q)
                            mem_we_n_q <= WE_ACTIVE;
                    end else begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        if (wr_q)
                            resp_rdata_q <= '0;
                        else if (word_q)
                            resp_rdata_q <= mem_rdata;
                        else
                            resp_rdata_q <= byte_ext(mem_rdata[7:0], sgn_q);
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_we_n_q  <= ~WE_ACTIVE;
                        mem_size_q  <= SIZE_BYTE;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_size   = mem_size_q;
    // Reset masks a strobe already registered low, so a store cut by rst never reaches memory.
    assign mem_we_n   = mem_we_n_q | rst;

endmodule

// File: doc/lc3b_mem_access.md
Name: lc3b_mem_access

Overview:
- Initiator side of the LC-3b byte-addressed data-memory interface.
- Accepts one load/store request at a time from the datapath (LDB/LDW/STB/STW).
- Drives the memory's address, write-data, active-low write strobe and size lines, holding them for a programmable number of cycles.
- Returns byte-extended or word read data, or an error for misaligned or out-of-range accesses, through a valid/ready response.

Parameters:
- ADDR_W, 8, memory address width; memory depth is 2**ADDR_W bytes.
- WAIT_CYCLES, 1, extra cycles the memory bus is held before sampling or writing (0..15).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_write  input  1  1=store, 0=load
- req_word  input  1  1=16-bit access, 0=8-bit access
- req_signed  input  1  LDB sign-extend when 1, zero-extend when 0; ignored otherwise
- req_addr  input  16  byte address from the datapath
- req_wdata  input  16  store data; bits [7:0] only for byte stores
- resp_valid  output  1  response available
- resp_ready  input  1  datapath consumes response
- resp_rdata  output  16  load result; 0 for stores and errors
- resp_err  output  1  misaligned word access or address >= 2**ADDR_W
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  16  memory write data
- mem_we_n  output  1  memory write strobe, active low
- mem_size  output  1  1=16-bit, 0=8-bit
- mem_rdata  input  16  memory read data; byte reads are {8'h00,byte}

Behaviour:
- Single clock domain. Reset is synchronous and active-high; clock and reset ports are named clk and rst.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_wdata=0, mem_we_n=1, mem_size=0, wait counter=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1, memory outputs at their reset values.
  - On req_valid, capture write, word, signed, addr and wdata in the same cycle.
  - Error case (req_word with req_addr[0]=1, or req_addr[15:ADDR_W]!=0): go to RESP with resp_err=1 and resp_rdata=0. No memory cycle is issued and mem_we_n stays 1.
  - Otherwise go to ACCESS and load the counter with WAIT_CYCLES.
- ACCESS: mem_addr=addr[ADDR_W-1:0], mem_size=word, and mem_wdata = wdata (word) or {8'h00, wdata[7:0]} (byte), all stable for WAIT_CYCLES+1 cycles.
  - The counter decrements each cycle. The final cycle is counter==0.
  - Store: mem_we_n=0 in the final ACCESS cycle only, exactly one cycle, with address, data and size already stable for the whole hold.
  - Load: mem_we_n=1 throughout. mem_rdata is registered in the final cycle.
  - Byte load: resp_rdata = {{8{signed&rdata[7]}}, rdata[7:0]}. Word load: resp_rdata = rdata.
  - After the final cycle go to RESP.
- RESP: resp_valid=1, memory outputs back at their reset values, mem_we_n=1.
  - Hold resp_rdata and resp_err stable until resp_ready.
  - On resp_valid&resp_ready go to IDLE; req_ready rises the next cycle. No back-to-back acceptance in RESP.
- Latency from accept to resp_valid: WAIT_CYCLES+2 cycles for a normal access, 1 cycle for an error.
- Word address 2**ADDR_W-2 is legal; the memory handles the +1 byte. No wrap is generated here.
- req_valid while not in IDLE is ignored (req_ready=0). The requester must hold req_valid and request fields until accepted.
- rst in any state returns to IDLE at that edge. A pending store whose strobe cycle coincides with rst is not issued: mem_we_n=1 after the edge. Any pending response is dropped.

Decomposition:
- Shared package lc3b_pkg holds:
  - state encoding for IDLE/ACCESS/RESP;
  - constants SIZE_BYTE=1'b0, SIZE_WORD=1'b1, WE_ACTIVE=1'b0;
  - a function for byte sign/zero extension to 16 bits.
- No sub-module is required. The extension logic may optionally be a small combinational lc3b_byte_ext, reusable by the LDB datapath.

Test Plan:
- Run all scenarios against a behavioural memory model preloaded with word[40]=16'h0026, byte[16]=8'h34, byte[17]=8'h0C, byte[50]=8'hF0.
- LDW addr 40, WAIT_CYCLES=1 -> mem_size=1 and mem_we_n=1 for 2 cycles; resp_valid 3 cycles after accept; resp_rdata=16'h0026, resp_err=0.
- LDB signed addr 50, then LDB unsigned addr 50 -> resp_rdata=16'hFFF0, then 16'h00F0.
- STW 16'h03E8 to addr 42, then LDW addr 42 -> mem_we_n low exactly 1 cycle with mem_addr=42 and mem_wdata=16'h03E8; readback 16'h03E8. STB 16'hAB77 to addr 16 -> byte[16]=8'h77, byte[17] unchanged 8'h0C.
- LDW addr 41, and LDB addr 16'h0100 with ADDR_W=8 -> resp_err=1, resp_rdata=0, mem_we_n never low, latency 1 cycle.
- Assert rst in the final ACCESS cycle of STW to addr 60 -> mem_we_n stays 1, memory unchanged, req_ready=1 and resp_valid=0 next cycle.
- Hold resp_ready=0 for 5 cycles in RESP while toggling req_valid -> resp_rdata stable, req_ready=0, no new memory cycle; accepted only after the handshake.
